// File: rtl/dcpu_mem_ctrl.sv
// Memory/IO controller for the dcpu bus master: routes each request to an
// internal word RAM or to an external IO window and returns a one-cycle ack.
module dcpu_mem_ctrl #(
  parameter int unsigned       W          = 16,
  parameter int unsigned       AW         = 12,
  parameter int unsigned       WAIT       = 1,
  parameter logic [W-1:0]      IO_BASE    = 16'hFF00,
  parameter int unsigned       IO_TIMEOUT = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_cpu_addr,
  input  logic [W-1:0] i_cpu_dat,
  output logic [W-1:0] o_cpu_dat,
  input  logic         i_cpu_we,
  input  logic         i_cpu_cs,
  output logic         o_cpu_ack,
  output logic [7:0]   o_io_addr,
  output logic [W-1:0] o_io_dat,
  input  logic [W-1:0] i_io_dat,
  output logic         o_io_we,
  output logic         o_io_stb,
  input  logic         i_io_ack,
  output logic         o_bus_err
);

  typedef enum logic [1:0] {IDLE, RAMWAIT, IOWAIT, ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT);
  localparam logic [7:0] TO_INIT   = 8'(IO_TIMEOUT);

  state_t         state_q;
  logic [7:0]     addr_q;
  logic [W-1:0]   wdat_q;
  logic           we_q;
  logic [W-1:0]   rdat_q;
  logic [W-1:0]   ram_rd_q;
  logic           ack_q;
  logic           stb_q;
  logic           io_we_q;
  logic           err_q;
  logic [3:0]     wcnt_q;
  logic [7:0]     tcnt_q;

  logic [W-1:0]   mem_q [2**AW];

  logic [AW-1:0]  ram_idx_s;
  logic           is_io_s;
  logic           ram_wr_s;
  logic [W-1:0]   ram_rdata_s;

  // Upper address bits are ignored by the RAM, so high RAM addresses alias.
  assign ram_idx_s   = i_cpu_addr[AW-1:0];
  assign is_io_s     = (i_cpu_addr >= IO_BASE);
  assign ram_wr_s    = i_reset_n && (state_q == IDLE) && i_cpu_cs && !is_io_s && i_cpu_we;
  assign ram_rdata_s = mem_q[ram_idx_s];

  // RAM write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (ram_wr_s) begin
      mem_q[ram_idx_s] <= i_cpu_dat;
    end
  end

  // Request decode, wait-state counting, IO handshake and completion.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      addr_q   <= 8'h00;
      wdat_q   <= '0;
      we_q     <= 1'b0;
      rdat_q   <= '0;
      ram_rd_q <= '0;
      ack_q    <= 1'b0;
      stb_q    <= 1'b0;
      io_we_q  <= 1'b0;
      err_q    <= 1'b0;
      wcnt_q   <= 4'd0;
      tcnt_q   <= 8'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_cpu_cs) begin
            addr_q <= i_cpu_addr[7:0];
            wdat_q <= i_cpu_dat;
            we_q   <= i_cpu_we;
            if (is_io_s) begin
              state_q <= IOWAIT;
              stb_q   <= 1'b1;
              io_we_q <= i_cpu_we;
              tcnt_q  <= TO_INIT;
            end else if (WAIT == 0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              if (!i_cpu_we) begin
                rdat_q <= ram_rdata_s;
              end
            end else begin
              state_q <= RAMWAIT;
              wcnt_q  <= WAIT_INIT;
              if (!i_cpu_we) begin
                ram_rd_q <= ram_rdata_s;
              end
            end
          end
        end
        RAMWAIT: begin
          if (wcnt_q == 4'd1) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            if (!we_q) begin
              rdat_q <= ram_rd_q;
            end
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        IOWAIT: begin
          // A late ack arriving on the final timeout cycle still wins.
          if (i_io_ack) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            stb_q   <= 1'b0;
            io_we_q <= 1'b0;
            if (!we_q) begin
              rdat_q <= i_io_dat;
            end
          end else if (tcnt_q == 8'd1) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            stb_q   <= 1'b0;
            io_we_q <= 1'b0;
            if (!we_q) begin
              rdat_q <= '0;
            end
          end else begin
            tcnt_q <= tcnt_q - 8'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_cpu_dat = rdat_q;
  assign o_cpu_ack = ack_q;
  assign o_io_addr = addr_q;
  assign o_io_dat  = wdat_q;
  assign o_io_we   = io_we_q;
  assign o_io_stb  = stb_q;
  assign o_bus_err = err_q;

endmodule
